// File: rtl/vga_mode_ctrl.sv
// rtl/vga_mode_ctrl.sv - VGA mode switch controller; optional custom mode 3 via VGA_MODE_CTRL_CUSTOM_EN
module vga_mode_ctrl #(
  parameter int BLANK_FRAMES = 2,
  parameter int VS_TIMEOUT   = 2000000
) (
  input  logic        pixel_clk,
  input  logic        pixel_rstn,
  input  logic [1:0]  mode_sel,
  input  logic        mode_valid,
  output logic        mode_ready,
  output logic        mode_done,
  output logic [1:0]  active_mode,
  input  logic        vs_in,
  input  logic [15:0] img_color_in,
  input  logic [15:0] border_color_in,
`ifdef VGA_MODE_CTRL_CUSTOM_EN
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
`endif
  output logic [15:0] InImage_Color,
  output logic [15:0] OutImage_Color,
  output logic [31:0] H_Sync,
  output logic [31:0] H_BP,
  output logic [31:0] H_FP,
  output logic [31:0] H_Range,
  output logic [31:0] H_LR_Border,
  output logic [31:0] V_Sync,
  output logic [31:0] V_BP,
  output logic [31:0] V_FP,
  output logic [31:0] V_Range,
  output logic [31:0] V_TB_Border
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VS = 2'd1;
  localparam logic [1:0] S_BLANK   = 2'd2;

  // Timing sets, order H Sync/BP/FP/Range/Border then V Sync/BP/FP/Range/Border
  localparam logic [0:9][31:0] M0_TIM = {32'd96, 32'd48, 32'd16, 32'd640, 32'd0,
                                         32'd2,  32'd33, 32'd10, 32'd480, 32'd0};
  localparam logic [0:9][31:0] M1_TIM = {32'd120, 32'd64, 32'd56, 32'd800, 32'd0,
                                         32'd6,   32'd23, 32'd37, 32'd600, 32'd0};
  localparam logic [0:9][31:0] M2_TIM = {32'd96, 32'd48, 32'd16, 32'd480, 32'd80,
                                         32'd2,  32'd33, 32'd10, 32'd400, 32'd40};

  localparam logic [31:0] TO_LAST    = 32'(VS_TIMEOUT - 1);
  localparam logic [3:0]  BLANK_LAST = 4'(BLANK_FRAMES - 1);

  logic [1:0]            r_state;
  logic [1:0]            r_mode;
  logic                  r_vs_prev;
  logic [31:0]           r_to_cnt;
  logic [3:0]            r_blank_cnt;
  logic                  r_done;
  logic [1:0]            r_active;
  logic [0:9][31:0]      r_tim;
  logic [0:9][31:0]      w_tim;
  logic                  w_timeout;
  logic                  w_edge;

`ifdef VGA_MODE_CTRL_CUSTOM_EN
  logic [0:9][31:0]      r_cust;

  // Custom timing registers, writable in any state; addresses 10..15 have no target
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rstn) begin
      r_cust <= M0_TIM;
    end else if (cfg_wr && (cfg_addr < 4'd10)) begin
      r_cust[cfg_addr] <= cfg_wdata;
    end
  end
`endif

  // A real VS fall and a timeout in the same cycle collapse into one edge
  assign w_timeout = (r_to_cnt == TO_LAST);
  assign w_edge    = (r_vs_prev & ~vs_in) | w_timeout;

  // Select the timing set for the captured mode; mode 3 falls back to mode 0 without custom regs
  always_comb begin
    w_tim = M0_TIM;
    case (r_mode)
      2'd1: w_tim = M1_TIM;
      2'd2: w_tim = M2_TIM;
`ifdef VGA_MODE_CTRL_CUSTOM_EN
      2'd3: w_tim = r_cust;
`endif
      default: w_tim = M0_TIM;
    endcase
  end

  // Mode change FSM: accept in IDLE, load timing on next VS edge, then blank for BLANK_FRAMES edges
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rstn) begin
      r_state     <= S_WAIT_VS;
      r_mode      <= 2'd0;
      r_vs_prev   <= 1'b1;
      r_to_cnt    <= 32'd0;
      r_blank_cnt <= 4'd0;
      r_done      <= 1'b0;
      r_active    <= 2'd0;
      r_tim       <= M0_TIM;
    end else begin
      r_vs_prev <= vs_in;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= 32'd0;
          if (mode_valid) begin
            r_mode  <= mode_sel;
            r_state <= S_WAIT_VS;
          end
        end
        S_WAIT_VS: begin
          if (w_edge) begin
            r_tim       <= w_tim;
            r_active    <= r_mode;
            r_state     <= S_BLANK;
            r_to_cnt    <= 32'd0;
            r_blank_cnt <= 4'd0;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        S_BLANK: begin
          if (w_edge) begin
            r_to_cnt <= 32'd0;
            if (r_blank_cnt == BLANK_LAST) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_blank_cnt <= 4'd0;
            end else begin
              r_blank_cnt <= r_blank_cnt + 4'd1;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_to_cnt <= 32'd0;
        end
      endcase
    end
  end

  assign mode_ready     = (r_state == S_IDLE);
  assign mode_done      = r_done;
  assign active_mode    = r_active;
  assign InImage_Color  = (r_state == S_IDLE) ? img_color_in    : 16'd0;
  assign OutImage_Color = (r_state == S_IDLE) ? border_color_in : 16'd0;
  assign H_Sync         = r_tim[0];
  assign H_BP           = r_tim[1];
  assign H_FP           = r_tim[2];
  assign H_Range        = r_tim[3];
  assign H_LR_Border    = r_tim[4];
  assign V_Sync         = r_tim[5];
  assign V_BP           = r_tim[6];
  assign V_FP           = r_tim[7];
  assign V_Range        = r_tim[8];
  assign V_TB_Border    = r_tim[9];

endmodule

// File: doc/vga_mode_ctrl.md
VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

Interface
REQ-001 SHALL provide parameter BLANK_FRAMES, default 2, number of VS falling edges blanked after a mode change; legal range 1..15.
REQ-002 SHALL provide parameter VS_TIMEOUT, default 2000000, pixel_clk cycles without a VS falling edge before a synthetic edge is generated.
REQ-003 pixel_clk  in  1  single clock for all logic.
REQ-004 pixel_rstn  in  1  reset; synchronous, active-low.
REQ-005 mode_sel  in  2  requested mode index.
REQ-006 mode_valid  in  1  mode request strobe.
REQ-007 mode_ready  out  1  high when a request can be accepted.
REQ-008 mode_done  out  1  one-cycle pulse when a mode change completes.
REQ-009 active_mode  out  2  index of the mode currently driven on the timing outputs.
REQ-010 vs_in  in  1  VGA_VS returned from the timing generator.
REQ-011 img_color_in / border_color_in  in  16 each  requested inner and border colours.
REQ-012 InImage_Color / OutImage_Color  out  16 each  colours to the timing generator.
REQ-013 H_Sync, H_BP, H_FP, H_Range, H_LR_Border  out  32 each  horizontal timing to the timing generator.
REQ-014 V_Sync, V_BP, V_FP, V_Range, V_TB_Border  out  32 each  vertical timing to the timing generator.
REQ-015 cfg_wr, cfg_addr[3:0], cfg_wdata[31:0]  in  custom-mode write port; present only with the configuration macro.

Function
REQ-016 Mode table, with parameters in the order Sync/BP/FP/Range/Border:
  - Mode 0, H 96/48/16/640/0, V 2/33/10/480/0.
  - Mode 1, H 120/64/56/800/0, V 6/23/37/600/0.
  - Mode 2, H 96/48/16/480/80, V 2/33/10/400/40.
  - Mode 3, custom, per REQ-027.
REQ-017 VS fall SHALL be detected on vs_in using a one-cycle registered copy: previous=1 and current=0.
REQ-018 States SHALL be IDLE, WAIT_VS and BLANK; mode_ready=1 only in IDLE.
REQ-019 Accept SHALL occur when mode_valid && mode_ready; mode_sel is captured and the next state is WAIT_VS.
REQ-020 From the cycle after accept, both colour outputs SHALL be 0 (blank) until completion.
REQ-021 In WAIT_VS, on a VS fall, all ten timing outputs and active_mode SHALL load the captured mode at the next clock edge, with a transition to BLANK.
REQ-022 In BLANK, the block SHALL count VS falls; on the BLANK_FRAMES-th fall it SHALL go to IDLE, pulse mode_done for one cycle, and resume colour pass-through the next cycle.
REQ-023 mode_valid while mode_ready=0 SHALL be ignored, with no queuing.
REQ-024 Timing outputs SHALL never change except at the REQ-021 load edge.
REQ-025 Timeout: a 32-bit counter SHALL run in WAIT_VS and BLANK, clear on each VS fall and on each state entry, and on reaching VS_TIMEOUT-1 act as a VS fall and clear.
REQ-026 A VS fall and a timeout in the same cycle SHALL count as one edge.

Configuration
REQ-027 Macro VGA_MODE_CTRL_CUSTOM_EN:
  - Defined: ten 32-bit custom registers written by cfg_wr at cfg_addr 0..9, in REQ-013 then REQ-014 order. Writes to cfg_addr 10..15 are ignored. Registers reset to the mode 0 values and can be written in any state. Mode 3 loads these registers at REQ-021.
  - Undefined: the cfg_* ports are absent. Mode 3 loads the mode 0 values, and active_mode reports 3.

Reset
REQ-028 While pixel_rstn=0 at a clock edge, the next state SHALL be:
  - Timing outputs at the mode 0 values, active_mode=0.
  - Colour outputs 0, mode_ready=0, mode_done=0.
  - State WAIT_VS with captured mode 0, counters 0, edge register 1.
REQ-029 Reset asserted in any state, including mid-change, SHALL abandon the change and restore the REQ-028 values on the next edge.

Verification
REQ-030 Release reset, vs_in low for 2 of every 1000 cycles -> mode 0 values; colours 0 until the 3rd VS fall, then pass-through; mode_done pulses once; mode_ready=1.
REQ-031 Mode 1 requested in IDLE -> mode_ready=0 the next cycle; H_Range stays 640 until 1 cycle after the next VS fall, then becomes 800; mode_done follows 2 falls later.
REQ-032 mode_valid with mode_sel=2 while in BLANK -> ignored; active_mode remains 1 and H_LR_Border remains 0.
REQ-033 vs_in held at 1, VS_TIMEOUT=100, mode 2 accepted -> load 100 cycles after WAIT_VS entry; mode_done 200 cycles after that.
REQ-034 With the macro: write cfg_addr 3 = 1024, then select mode 3 -> H_Range=1024. Without the macro, mode 3 -> H_Range=640 and active_mode=3.
REQ-035 pixel_rstn low for 1 cycle in BLANK after mode 1 -> H_Range=640, colours 0, mode_ready=0 the next cycle.
